// File: rtl/gate_array_pipe_if.sv
// Handshake bus for gate_array_pipe: operand stream in, result stream out.
interface gate_array_pipe_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned NIN = 3,
    parameter int unsigned W   = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*NIN*W-1:0] in_data;
    logic [2:0]           op;
    logic                 redmode;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH-1:0]       out_data;

    // Producer/consumer side driving the block
    modport master (
        output in_valid, in_data, op, redmode, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The gate array itself
    modport slave (
        input  in_valid, in_data, op, redmode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gate_array_pipe.sv
// NCH parallel NIN-input gates over W-bit operands, results buffered in a
// 2-entry valid/ready queue, with accounting of LSB-mode operand truncation.
module gate_array_pipe #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned NIN  = 3,
    parameter int unsigned W    = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic              clk,
    input  logic              rst,
    gate_array_pipe_if.slave  bus,
    output logic [CNTW-1:0]   trunc_cnt,
    output logic              trunc_flag
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]     count;
    logic [1:0]     count_nxt;
    logic [NCH-1:0] q0;
    logic [NCH-1:0] q1;
    logic [NCH-1:0] q0_nxt;
    logic [NCH-1:0] q1_nxt;
    logic [NCH-1:0] res;
    logic [NCH-1:0] trunc_ch;
    logic           push;
    logic           pop;
    logic           trunc;

    // Handshake status is a pure decode of the registered occupancy
    assign bus.in_ready  = (count != CNT_FULL);
    assign bus.out_valid = (count != CNT_EMPTY);
    assign bus.out_data  = q0;

    assign push  = bus.in_valid & (count != CNT_FULL);
    assign pop   = bus.out_ready & (count != CNT_EMPTY);
    assign trunc = ~bus.redmode & (|trunc_ch);

    genvar c;
    for (c = 0; c < NCH; c++) begin : g_ch
        logic [NIN-1:0] s;
        logic [NIN-1:0] hi;
        logic [W-1:0]   opnd;
        logic           r;

        // Scalarise each operand and note any discarded upper bits
        always_comb begin
            s    = '0;
            hi   = '0;
            opnd = '0;
            for (int i = 0; i < NIN; i++) begin
                opnd  = bus.in_data[(c*NIN + i)*W +: W];
                s[i]  = bus.redmode ? (|opnd) : opnd[0];
                hi[i] = |(opnd >> 1);
            end
        end

        // Apply the selected gate across this channel's scalars
        always_comb begin
            r = 1'b0;
            case (bus.op)
                3'd0:    r = &s;
                3'd1:    r = |s;
                3'd2:    r = ^s;
                3'd3:    r = ~(&s);
                3'd4:    r = ~(|s);
                3'd5:    r = ~(^s);
                3'd6:    r = s[0];
                default: r = ~s[0];
            endcase
        end

        assign res[c]      = r;
        assign trunc_ch[c] = |hi;
    end

    // Queue next state: q0 is always the head, cleared when empty
    always_comb begin
        count_nxt = count;
        q0_nxt    = q0;
        q1_nxt    = q1;
        case (count)
            CNT_EMPTY: begin
                if (push) begin
                    q0_nxt    = res;
                    count_nxt = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push && pop) begin
                    q0_nxt = res;
                end else if (push) begin
                    q1_nxt    = res;
                    count_nxt = CNT_FULL;
                end else if (pop) begin
                    q0_nxt    = '0;
                    count_nxt = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                if (pop) begin
                    q0_nxt    = q1;
                    q1_nxt    = '0;
                    count_nxt = CNT_ONE;
                end
            end
            default: begin
                count_nxt = CNT_EMPTY;
                q0_nxt    = '0;
                q1_nxt    = '0;
            end
        endcase
    end

    // Queue state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_EMPTY;
            q0    <= '0;
            q1    <= '0;
        end else begin
            count <= count_nxt;
            q0    <= q0_nxt;
            q1    <= q1_nxt;
        end
    end

    // Saturating truncation counter and sticky flag, on accepted beats only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trunc_cnt  <= '0;
            trunc_flag <= 1'b0;
        end else if (push && trunc) begin
            trunc_flag <= 1'b1;
            if (trunc_cnt != {CNTW{1'b1}}) begin
                trunc_cnt <= trunc_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed bench for gate_array_pipe: gate truth vectors, backpressure,
// counter saturation and asynchronous reset.
module tb_gate_array_pipe;

    localparam int unsigned NCH = 4;
    localparam int unsigned NIN = 3;
    localparam int unsigned W   = 4;

    localparam logic [47:0] D_TWO = 48'h2222_2222_2222;
    localparam logic [47:0] D_MIX = 48'h1110_1111_1111;
    localparam logic [47:0] D_LOW = 48'h0000_0000_0003;

    logic clk;
    logic rst;
    logic [7:0] cnt_a;
    logic       flag_a;
    logic [1:0] cnt_b;
    logic       flag_b;

    int n_cmp;
    int n_fail;

    gate_array_pipe_if #(.NCH(NCH), .NIN(NIN), .W(W)) bus_a ();
    gate_array_pipe_if #(.NCH(NCH), .NIN(NIN), .W(W)) bus_b ();

    gate_array_pipe #(.NCH(NCH), .NIN(NIN), .W(W), .CNTW(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .trunc_cnt  (cnt_a),
        .trunc_flag (flag_a)
    );

    gate_array_pipe #(.NCH(NCH), .NIN(NIN), .W(W), .CNTW(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_b),
        .trunc_cnt  (cnt_b),
        .trunc_flag (flag_b)
    );

    typedef struct {
        logic [47:0] data;
        logic [2:0]  op;
        logic        rm;
        logic [3:0]  exp_out;
        logic [7:0]  exp_cnt;
        logic        exp_flag;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{D_TWO, 3'd0, 1'b0, 4'b0000, 8'd1, 1'b1};
        vecs[1]  = '{D_TWO, 3'd0, 1'b1, 4'b1111, 8'd1, 1'b1};
        vecs[2]  = '{D_MIX, 3'd2, 1'b0, 4'b1011, 8'd1, 1'b1};
        vecs[3]  = '{D_MIX, 3'd7, 1'b0, 4'b0000, 8'd1, 1'b1};
        vecs[4]  = '{D_MIX, 3'd4, 1'b0, 4'b0000, 8'd1, 1'b1};
        vecs[5]  = '{D_MIX, 3'd1, 1'b0, 4'b1111, 8'd1, 1'b1};
        vecs[6]  = '{D_MIX, 3'd3, 1'b0, 4'b0100, 8'd1, 1'b1};
        vecs[7]  = '{D_MIX, 3'd5, 1'b0, 4'b0100, 8'd1, 1'b1};
        vecs[8]  = '{D_MIX, 3'd6, 1'b0, 4'b1111, 8'd1, 1'b1};
        vecs[9]  = '{D_MIX, 3'd0, 1'b0, 4'b1011, 8'd1, 1'b1};
        vecs[10] = '{D_TWO, 3'd6, 1'b0, 4'b0000, 8'd2, 1'b1};
        vecs[11] = '{D_LOW, 3'd1, 1'b0, 4'b0001, 8'd3, 1'b1};

        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.op = '0;
        bus_a.redmode = 1'b0;  bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.op = '0;
        bus_b.redmode = 1'b0;  bus_b.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_data",  32'(bus_a.out_data),  32'd0);
        check("rst_cnt",       32'(cnt_a),           32'd0);
        check("rst_flag",      32'(flag_a),          32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: back-to-back accepts with the consumer always ready
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus_a.in_data = vecs[k].data;
            bus_a.op      = vecs[k].op;
            bus_a.redmode = vecs[k].rm;
            tick();
            check($sformatf("vec%0d_valid", k), 32'(bus_a.out_valid), 32'd1);
            check($sformatf("vec%0d_data", k),  32'(bus_a.out_data),  32'(vecs[k].exp_out));
            check($sformatf("vec%0d_cnt", k),   32'(cnt_a),           32'(vecs[k].exp_cnt));
            check($sformatf("vec%0d_flag", k),  32'(flag_a),          32'(vecs[k].exp_flag));
        end
        bus_a.in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(bus_a.out_valid), 32'd0);
        check("drain_data",  32'(bus_a.out_data),  32'd0);

        // Backpressure: A=XOR(1011), B=NAND(0100), C=OR(1111)
        bus_a.out_ready = 1'b0;
        bus_a.redmode   = 1'b0;
        bus_a.in_data   = D_MIX;
        bus_a.in_valid  = 1'b1;
        bus_a.op        = 3'd2;
        tick();
        check("bp_a_valid", 32'(bus_a.out_valid), 32'd1);
        check("bp_a_data",  32'(bus_a.out_data),  32'b1011);
        check("bp_a_ready", 32'(bus_a.in_ready),  32'd1);
        bus_a.op = 3'd3;
        tick();
        check("bp_full_ready", 32'(bus_a.in_ready), 32'd0);
        check("bp_full_data",  32'(bus_a.out_data), 32'b1011);
        bus_a.op = 3'd1;
        tick();
        check("bp_hold_ready", 32'(bus_a.in_ready), 32'd0);
        check("bp_hold_data",  32'(bus_a.out_data), 32'b1011);
        bus_a.out_ready = 1'b1;
        tick();
        check("bp_pop_ready", 32'(bus_a.in_ready), 32'd1);
        check("bp_pop_data",  32'(bus_a.out_data), 32'b0100);
        bus_a.out_ready = 1'b0;
        tick();
        bus_a.in_valid = 1'b0;
        check("bp_c_ready", 32'(bus_a.in_ready), 32'd0);
        check("bp_c_data",  32'(bus_a.out_data), 32'b0100);
        bus_a.out_ready = 1'b1;
        tick();
        check("bp_c_head", 32'(bus_a.out_data), 32'b1111);
        tick();
        check("bp_end_valid", 32'(bus_a.out_valid), 32'd0);
        check("bp_end_data",  32'(bus_a.out_data),  32'd0);

        // Saturation on the 2-bit counter instance
        bus_b.out_ready = 1'b1;
        bus_b.in_data   = D_TWO;
        bus_b.op        = 3'd0;
        bus_b.redmode   = 1'b0;
        bus_b.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sat%0d_cnt", k), 32'(cnt_b), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        bus_b.in_valid = 1'b0;
        check("sat_flag", 32'(flag_b), 32'd1);

        // Fill the queue, then reset asynchronously mid-cycle
        bus_a.out_ready = 1'b0;
        bus_a.in_data   = D_TWO;
        bus_a.op        = 3'd0;
        bus_a.redmode   = 1'b0;
        bus_a.in_valid  = 1'b1;
        tick();
        tick();
        bus_a.in_valid = 1'b0;
        check("pre_rst_ready", 32'(bus_a.in_ready), 32'd0);
        check("pre_rst_cnt",   32'(cnt_a),          32'd5);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(bus_a.out_valid), 32'd0);
        check("arst_data",   32'(bus_a.out_data),  32'd0);
        check("arst_ready",  32'(bus_a.in_ready),  32'd1);
        check("arst_cnt",    32'(cnt_a),           32'd0);
        check("arst_flag",   32'(flag_a),          32'd0);
        check("arst_cnt_b",  32'(cnt_b),           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First transaction after reset: one cycle latency
        bus_a.out_ready = 1'b1;
        bus_a.in_data   = D_MIX;
        bus_a.op        = 3'd2;
        bus_a.in_valid  = 1'b1;
        check("post_rst_idle", 32'(bus_a.out_valid), 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check("post_rst_valid", 32'(bus_a.out_valid), 32'd1);
        check("post_rst_data",  32'(bus_a.out_data),  32'b1011);
        check("post_rst_cnt",   32'(cnt_a),           32'd0);
        check("post_rst_flag",  32'(flag_a),          32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, registered successor to the single-gate wide-input primitive model.
- Evaluates NCH independent N-input logic gates per transaction. Each gate's inputs are W-bit operands, collapsed to scalars either by taking the LSB or by reduction-OR.
- Results are buffered in a 2-entry valid/ready output queue.
- Operands that are silently truncated in LSB mode are counted, so they are visible to the lint/cosim bench.

Parameters:
- NCH, 4, number of gate channels (≥1)
- NIN, 3, inputs per gate (≥1)
- W, 4, width of each input operand (≥1)
- CNTW, 8, width of the truncation counter (≥1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  transaction offered
- in_ready  output  1  block can accept a transaction this cycle
- in_data  input  NCH*NIN*W  operands; operand o[c][i] = in_data[(c*NIN+i)*W +: W]
- op  input  3  gate type, sampled with in_data
- redmode  input  1  0 = LSB scalarisation, 1 = reduction-OR scalarisation; sampled with in_data
- out_valid  output  1  queue head holds a result
- out_ready  input  1  consumer accepts the head
- out_data  output  NCH  head result; bit c = gate c
- trunc_cnt  output  CNTW  saturating count of truncating transactions
- trunc_flag  output  1  sticky: at least one truncation since reset

Behaviour:
- Scalarisation: s[c][i] = redmode ? |o[c][i] : o[c][i][0].
- Op encoding, applied across s[c][0..NIN-1]:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR
  - 6 BUF: s[c][0]
  - 7 NOT: ~s[c][0]
  - NIN=1 with ops 0–5 degenerates to buf/not of s[c][0].
- Acceptance: a transaction is accepted on a rising edge where in_valid & in_ready. The result is computed combinationally from in_data/op/redmode and pushed into the queue on that edge.
- Latency: exactly 1 cycle. A result accepted at edge t is visible at out_data with out_valid=1 after edge t when the queue was empty.
- Queue: 2 entries, FIFO order.
  - count ∈ {0,1,2}; in_ready = (count != 2); out_valid = (count != 0).
  - in_ready depends only on registered state; there is no out_ready→in_ready combinational path.
  - count==2 with out_ready=1: pop only, in_ready stays 0 that cycle.
  - count==1 with push and pop on the same edge: count stays 1, new result becomes head.
  - count==0: pop is impossible; out_ready is ignored.
  - out_data reflects the head entry; it is 0 when count==0.
  - out_data holds stable while out_valid & ~out_ready.
- Truncation accounting, on accepted transactions only:
  - A transaction truncates if redmode==0 and any operand of any channel has o[c][i][W-1:1] != 0.
  - On such an edge, trunc_cnt increments by 1, saturating at 2^CNTW-1.
  - trunc_flag is set to 1 and stays set until rst.
  - When W==1, no truncation is possible.
  - redmode==1 transactions never count.
- Reset, asynchronous and immediate:
  - count=0, so in_ready=1 (combinational from count) and out_valid=0.
  - out_data=0, trunc_cnt=0, trunc_flag=0.
  - Queue contents are discarded mid-stream; no partial result survives.
- X/Z on inputs: not modelled; two-state behaviour only.

Test Plan:
- NCH=4, NIN=3, W=4. All operands 4'b0010, op=0 (AND), redmode=0, one accept → next cycle out_valid=1, out_data=4'b0000, trunc_cnt=1, trunc_flag=1.
- Same in_data, redmode=1, op=0 → out_data=4'b1111; trunc_cnt unchanged.
- Channel 2 operands {4'b0001, 4'b0001, 4'b0000}, all other operands 4'b0001, redmode=0:
  - op=2 (XOR) → out_data=4'b1011.
  - op=7 (NOT) → out_data=4'b0000.
  - op=4 (NOR) → out_data=4'b0000.
- Backpressure: out_ready=0, offer 3 transactions back-to-back → first two accepted, then in_ready=0 and the third is held. Raise out_ready for one cycle → head popped, in_ready=1 the following cycle, third accepted. FIFO order preserved.
- Saturation with CNTW=2: 5 truncating accepts → trunc_cnt=3 and holds; trunc_flag=1.
- Assert rst asynchronously with count=2 → out_valid=0, out_data=0, in_ready=1, trunc_cnt=0, trunc_flag=0 without waiting for a clock edge. The first post-reset accept yields a result after 1 cycle.
